// File: rtl/axis_req_arbiter.sv
// axis_req_arbiter
// Frame-aware two-requester arbiter sharing one AXI-Stream byte channel into
// axis_wb_master. A grant is locked on a command byte (CMD_READ / CMD_WRITE).
// It is held until the response frame ends with a tlast handshake. The next
// grant is then chosen round-robin. Abort and idle-timeout paths make sure
// the Wishbone master is never left owned by a requester that has gone away.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   s0_axis_* / s1_axis_*       request bytes from requester 0 / 1
//   m0_axis_* / m1_axis_*       response bytes to requester 0 / 1
//   abort0, abort1              requester abandons its frame (level)
//   m_axis_*                    request stream to axis_wb_master (tlast = 0)
//   s_axis_*                    response stream from axis_wb_master
//   grant                       one-hot owner, 2'b00 when idle
//   timeout_pulse               one-cycle pulse on forced release
//   drop_count                  saturating count of non-command bytes dropped in IDLE
//
// state | meaning
// IDLE  | no owner; non-command bytes dropped, command bytes arbitrated
// GRANT | owner's request/response streams passed through combinationally
// DRAIN | owner aborted; responses swallowed until tlast
module axis_req_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  CMD_READ       = 8'hA1,
    parameter logic [7:0]  CMD_WRITE      = 8'hA2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s0_axis_tdata,
    input  logic       s0_axis_tvalid,
    output logic       s0_axis_tready,
    output logic [7:0] m0_axis_tdata,
    output logic       m0_axis_tvalid,
    input  logic       m0_axis_tready,
    output logic       m0_axis_tlast,
    input  logic [7:0] s1_axis_tdata,
    input  logic       s1_axis_tvalid,
    output logic       s1_axis_tready,
    output logic [7:0] m1_axis_tdata,
    output logic       m1_axis_tvalid,
    input  logic       m1_axis_tready,
    output logic       m1_axis_tlast,
    input  logic       abort0,
    input  logic       abort1,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    output logic [1:0] grant,
    output logic       timeout_pulse,
    output logic [7:0] drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Counter value on the last idle cycle allowed before forced release.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic        last_served, last_served_nxt;
    logic [15:0] idle_cnt, idle_cnt_nxt;
    logic        timeout_pulse_nxt;
    logic [7:0]  drop_count_nxt;

    logic       is_cmd0, is_cmd1, req0, req1;
    logic       drop0, drop1;
    logic [8:0] drop_sum;
    logic       hs_any, resp_last_hs, abort_own;

    assign is_cmd0 = (s0_axis_tdata == CMD_READ) || (s0_axis_tdata == CMD_WRITE);
    assign is_cmd1 = (s1_axis_tdata == CMD_READ) || (s1_axis_tdata == CMD_WRITE);
    assign req0    = s0_axis_tvalid && is_cmd0;
    assign req1    = s1_axis_tvalid && is_cmd1;

    assign drop0    = (state == ST_IDLE) && s0_axis_tvalid && !is_cmd0;
    assign drop1    = (state == ST_IDLE) && s1_axis_tvalid && !is_cmd1;
    assign drop_sum = 9'(drop_count) + 9'(drop0) + 9'(drop1);
    assign drop_count_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    assign m_axis_tlast = 1'b0;
    assign grant        = (state == ST_IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
    assign abort_own    = owner ? abort1 : abort0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            owner         <= 1'b0;
            last_served   <= 1'b1;
            idle_cnt      <= 16'd0;
            timeout_pulse <= 1'b0;
            drop_count    <= 8'd0;
        end else begin
            state         <= state_nxt;
            owner         <= owner_nxt;
            last_served   <= last_served_nxt;
            idle_cnt      <= idle_cnt_nxt;
            timeout_pulse <= timeout_pulse_nxt;
            drop_count    <= drop_count_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        owner_nxt         = owner;
        last_served_nxt   = last_served;
        idle_cnt_nxt      = idle_cnt;
        timeout_pulse_nxt = 1'b0;
        s0_axis_tready    = 1'b0;
        s1_axis_tready    = 1'b0;
        m0_axis_tdata     = 8'd0;
        m0_axis_tvalid    = 1'b0;
        m0_axis_tlast     = 1'b0;
        m1_axis_tdata     = 8'd0;
        m1_axis_tvalid    = 1'b0;
        m1_axis_tlast     = 1'b0;
        m_axis_tdata      = 8'd0;
        m_axis_tvalid     = 1'b0;
        s_axis_tready     = 1'b0;
        hs_any            = 1'b0;
        resp_last_hs      = 1'b0;

        case (state)
            ST_IDLE: begin
                // Command bytes are held back so they become the first byte of the frame.
                s0_axis_tready = !is_cmd0;
                s1_axis_tready = !is_cmd1;
                idle_cnt_nxt   = 16'd0;
                if (req0 && req1) begin
                    owner_nxt = ~last_served;
                    state_nxt = ST_GRANT;
                end else if (req0) begin
                    owner_nxt = 1'b0;
                    state_nxt = ST_GRANT;
                end else if (req1) begin
                    owner_nxt = 1'b1;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!owner) begin
                    m_axis_tdata   = s0_axis_tdata;
                    m_axis_tvalid  = s0_axis_tvalid;
                    s0_axis_tready = m_axis_tready;
                    m0_axis_tdata  = s_axis_tdata;
                    m0_axis_tvalid = s_axis_tvalid;
                    m0_axis_tlast  = s_axis_tlast;
                    s_axis_tready  = m0_axis_tready;
                end else begin
                    m_axis_tdata   = s1_axis_tdata;
                    m_axis_tvalid  = s1_axis_tvalid;
                    s1_axis_tready = m_axis_tready;
                    m1_axis_tdata  = s_axis_tdata;
                    m1_axis_tvalid = s_axis_tvalid;
                    m1_axis_tlast  = s_axis_tlast;
                    s_axis_tready  = m1_axis_tready;
                end
            end
            ST_DRAIN: begin
                s_axis_tready = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (state != ST_IDLE) begin
            hs_any       = (m_axis_tvalid && m_axis_tready) || (s_axis_tvalid && s_axis_tready);
            resp_last_hs = s_axis_tvalid && s_axis_tready && s_axis_tlast;
            // Frame end beats both timeout and abort in the same cycle.
            if (resp_last_hs) begin
                state_nxt       = ST_IDLE;
                last_served_nxt = owner;
            end else if (!hs_any && (idle_cnt == TIMEOUT_LAST)) begin
                state_nxt         = ST_IDLE;
                last_served_nxt   = owner;
                timeout_pulse_nxt = 1'b1;
            end else begin
                idle_cnt_nxt = hs_any ? 16'd0 : idle_cnt + 16'd1;
                if ((state == ST_GRANT) && abort_own) begin
                    state_nxt = ST_DRAIN;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_req_arbiter.sv
module tb_axis_req_arbiter;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s0_axis_tdata, s1_axis_tdata, m0_axis_tdata, m1_axis_tdata;
    logic       s0_axis_tvalid, s0_axis_tready, s1_axis_tvalid, s1_axis_tready;
    logic       m0_axis_tvalid, m0_axis_tready, m0_axis_tlast;
    logic       m1_axis_tvalid, m1_axis_tready, m1_axis_tlast;
    logic       abort0, abort1;
    logic [7:0] m_axis_tdata, s_axis_tdata;
    logic       m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic       s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [1:0] grant;
    logic       timeout_pulse;
    logic [7:0] drop_count;

    int checks = 0;
    int failures = 0;

    axis_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
        .m0_axis_tdata(m0_axis_tdata), .m0_axis_tvalid(m0_axis_tvalid), .m0_axis_tready(m0_axis_tready),
        .m0_axis_tlast(m0_axis_tlast),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
        .m1_axis_tdata(m1_axis_tdata), .m1_axis_tvalid(m1_axis_tvalid), .m1_axis_tready(m1_axis_tready),
        .m1_axis_tlast(m1_axis_tlast),
        .abort0(abort0), .abort1(abort1),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .grant(grant), .timeout_pulse(timeout_pulse), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_cmd(input logic [7:0] d);
        return (d == 8'hA1) || (d == 8'hA2);
    endfunction

    // Behavioural model: who owns the channel, whether it is draining, idle
    // cycles in the frame, who was served last, bytes dropped so far.
    int m_own;      // -1 = nobody
    bit m_drain;
    int m_idle;
    int m_last;
    int m_drops;
    bit m_pulse;

    logic       e_s0r, e_s1r, e_mv, e_m0v, e_m0l, e_m1v, e_m1l, e_sr;
    logic [7:0] e_md, e_m0d, e_m1d;
    logic [1:0] e_grant;
    int         n_drop;
    bit         c0, c1, hs;

    always @(negedge clk) begin
        if (rst) begin
            m_own = -1; m_drain = 0; m_idle = 0; m_last = 1; m_drops = 0; m_pulse = 0;
        end
        e_s0r = 0; e_s1r = 0; e_mv = 0; e_md = 0; e_m0v = 0; e_m0l = 0; e_m0d = 0;
        e_m1v = 0; e_m1l = 0; e_m1d = 0; e_sr = 0;
        if (m_own < 0) begin
            e_s0r = !is_cmd(s0_axis_tdata);
            e_s1r = !is_cmd(s1_axis_tdata);
        end else if (m_drain) begin
            e_sr = 1;
        end else if (m_own == 0) begin
            e_mv = s0_axis_tvalid; e_md = s0_axis_tdata; e_s0r = m_axis_tready;
            e_m0v = s_axis_tvalid; e_m0l = s_axis_tlast; e_m0d = s_axis_tdata; e_sr = m0_axis_tready;
        end else begin
            e_mv = s1_axis_tvalid; e_md = s1_axis_tdata; e_s1r = m_axis_tready;
            e_m1v = s_axis_tvalid; e_m1l = s_axis_tlast; e_m1d = s_axis_tdata; e_sr = m1_axis_tready;
        end
        e_grant = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);

        chk("grant", grant, e_grant);
        chk("timeout_pulse", timeout_pulse, m_pulse);
        chk("drop_count", drop_count, m_drops);
        chk("m_axis_tvalid", m_axis_tvalid, e_mv);
        if (e_mv) chk("m_axis_tdata", m_axis_tdata, e_md);
        chk("m_axis_tlast", m_axis_tlast, 0);
        chk("s0_axis_tready", s0_axis_tready, e_s0r);
        chk("s1_axis_tready", s1_axis_tready, e_s1r);
        chk("m0_axis_tvalid", m0_axis_tvalid, e_m0v);
        chk("m0_axis_tlast", m0_axis_tlast, e_m0l);
        if (e_m0v) chk("m0_axis_tdata", m0_axis_tdata, e_m0d);
        chk("m1_axis_tvalid", m1_axis_tvalid, e_m1v);
        chk("m1_axis_tlast", m1_axis_tlast, e_m1l);
        if (e_m1v) chk("m1_axis_tdata", m1_axis_tdata, e_m1d);
        chk("s_axis_tready", s_axis_tready, e_sr);

        // Advance the model to what must hold after the coming rising edge.
        if (!rst) begin
            m_pulse = 0;
            if (m_own < 0) begin
                n_drop = 0;
                if (s0_axis_tvalid && !is_cmd(s0_axis_tdata)) n_drop++;
                if (s1_axis_tvalid && !is_cmd(s1_axis_tdata)) n_drop++;
                m_drops = (m_drops + n_drop > 255) ? 255 : m_drops + n_drop;
                c0 = s0_axis_tvalid && is_cmd(s0_axis_tdata);
                c1 = s1_axis_tvalid && is_cmd(s1_axis_tdata);
                m_idle = 0; m_drain = 0;
                if (c0 && c1) m_own = (m_last == 0) ? 1 : 0;
                else if (c0) m_own = 0;
                else if (c1) m_own = 1;
            end else begin
                hs = (e_mv && m_axis_tready) || (s_axis_tvalid && e_sr);
                if (s_axis_tvalid && e_sr && s_axis_tlast) begin
                    m_last = m_own; m_own = -1;
                end else if (!hs && (m_idle + 1 == TO)) begin
                    m_pulse = 1; m_last = m_own; m_own = -1;
                end else begin
                    m_idle = hs ? 0 : m_idle + 1;
                    if (!m_drain && ((m_own == 0) ? abort0 : abort1)) m_drain = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s0_axis_tdata = 0; s0_axis_tvalid = 0; s1_axis_tdata = 0; s1_axis_tvalid = 0;
        m0_axis_tready = 0; m1_axis_tready = 0; abort0 = 0; abort1 = 0;
        m_axis_tready = 1; s_axis_tdata = 0; s_axis_tvalid = 0; s_axis_tlast = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic set_req(input int p, input logic v, input logic [7:0] d);
        if (p == 0) begin s0_axis_tvalid = v; s0_axis_tdata = d; end
        else begin s1_axis_tvalid = v; s1_axis_tdata = d; end
    endtask

    task automatic set_resp_ready(input int p, input logic r);
        if (p == 0) m0_axis_tready = r; else m1_axis_tready = r;
    endtask

    // Single-requester frame: command, nreq request bytes, nresp response bytes.
    task automatic frame(input int p, input logic [7:0] cmd, input int nreq, input int nresp);
        logic [1:0] g;
        logic [7:0] rd;
        g = (p == 0) ? 2'b01 : 2'b10;
        m_axis_tready = 1;
        set_req(p, 1, cmd);
        tick();
        chk("frame_grant", grant, g);
        chk("frame_cmd_first", m_axis_tdata, cmd);
        for (int i = 0; i < nreq; i++) begin
            tick();
            set_req(p, 1, 8'(8'h40 + i));
        end
        tick();
        set_req(p, 0, 0);
        set_resp_ready(p, 1);
        for (int i = 0; i < nresp; i++) begin
            s_axis_tvalid = 1; s_axis_tdata = 8'(8'h80 + i); s_axis_tlast = (i == nresp - 1);
            #1;
            rd = (p == 0) ? m0_axis_tdata : m1_axis_tdata;
            chk("frame_resp_byte", rd, 8'(8'h80 + i));
            chk("frame_grant_held", grant, g);
            tick();
        end
        s_axis_tvalid = 0; s_axis_tlast = 0;
        set_resp_ready(p, 0);
        chk("frame_release", grant, 2'b00);
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        #2;
        chk("rst_grant", grant, 2'b00);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_m_axis_tvalid", m_axis_tvalid, 0);
        chk("rst_s0_tready_noncmd", s0_axis_tready, 1);
        do_reset();

        // Non-command bytes dropped, then command granted and forwarded first.
        set_req(1, 1, 8'h00);
        tick();
        set_req(1, 1, 8'h55);
        tick();
        set_req(1, 1, 8'hA1);
        #1;
        chk("idle_cmd_not_ready", s1_axis_tready, 0);
        tick();
        chk("drop_two", drop_count, 2);
        chk("drop_grant", grant, 2'b10);
        chk("drop_first_byte", m_axis_tdata, 8'hA1);
        chk("drop_first_valid", m_axis_tvalid, 1);
        tick();
        set_req(1, 0, 0);
        m1_axis_tready = 1; s_axis_tvalid = 1; s_axis_tdata = 8'h99; s_axis_tlast = 1;
        tick();
        s_axis_tvalid = 0; s_axis_tlast = 0; m1_axis_tready = 0;
        chk("drop_release", grant, 2'b00);

        // Contention right after reset: port 0 first, then port 1, then port 0 again.
        do_reset();
        set_req(0, 1, 8'hA2);
        set_req(1, 1, 8'hA2);
        tick();
        chk("rr_first_p0", grant, 2'b01);
        tick();
        set_req(0, 0, 0);
        m0_axis_tready = 1; s_axis_tvalid = 1; s_axis_tdata = 8'h33; s_axis_tlast = 1;
        tick();
        s_axis_tvalid = 0; s_axis_tlast = 0; m0_axis_tready = 0;
        chk("rr_release0", grant, 2'b00);
        tick();
        chk("rr_then_p1", grant, 2'b10);
        chk("rr_p1_cmd_kept", m_axis_tdata, 8'hA2);
        tick();
        set_req(1, 0, 0);
        m1_axis_tready = 1; s_axis_tvalid = 1; s_axis_tdata = 8'h44; s_axis_tlast = 1;
        tick();
        s_axis_tvalid = 0; s_axis_tlast = 0; m1_axis_tready = 0;
        set_req(0, 1, 8'hA2);
        set_req(1, 1, 8'hA2);
        tick();
        chk("rr_p1_loses", grant, 2'b01);
        tick();
        set_req(0, 0, 0);
        m0_axis_tready = 1; s_axis_tvalid = 1; s_axis_tdata = 8'h55; s_axis_tlast = 1;
        tick();
        s_axis_tvalid = 0; s_axis_tlast = 0; m0_axis_tready = 0;
        set_req(1, 0, 0);
        tick();

        // Full read frame through port 0.
        frame(0, 8'hA1, 6, 5);
        tick();

        // Abort after 3 request bytes: responses drained, requester sees nothing.
        set_req(0, 1, 8'hA1);
        tick();
        tick();
        set_req(0, 1, 8'h01);
        tick();
        set_req(0, 1, 8'h02);
        tick();
        set_req(0, 1, 8'h03);
        tick();
        set_req(0, 0, 0);
        abort0 = 1; abort1 = 1;
        tick();
        abort0 = 0; abort1 = 0;
        chk("abort_grant_held", grant, 2'b01);
        for (int i = 0; i < 4; i++) begin
            s_axis_tvalid = 1; s_axis_tdata = 8'(8'hC0 + i); s_axis_tlast = (i == 3);
            #1;
            chk("drain_ready", s_axis_tready, 1);
            chk("drain_m0_quiet", m0_axis_tvalid, 0);
            tick();
        end
        s_axis_tvalid = 0; s_axis_tlast = 0;
        chk("drain_release", grant, 2'b00);
        frame(1, 8'hA2, 1, 2);
        tick();

        // Timeout after exactly TO idle cycles.
        m_axis_tready = 0;
        set_req(0, 1, 8'hA1);
        tick();
        chk("to_grant", grant, 2'b01);
        for (int i = 1; i < TO; i++) begin
            tick();
            chk("to_no_pulse_yet", timeout_pulse, 0);
        end
        tick();
        set_req(0, 0, 0);
        chk("to_pulse", timeout_pulse, 1);
        chk("to_released", grant, 2'b00);
        tick();
        chk("to_pulse_one_cycle", timeout_pulse, 0);

        // tlast in the last allowed cycle wins over the timeout.
        set_req(0, 1, 8'hA1);
        tick();
        for (int i = 1; i < TO; i++) tick();
        set_req(0, 0, 0);
        m0_axis_tready = 1; s_axis_tvalid = 1; s_axis_tdata = 8'h77; s_axis_tlast = 1;
        tick();
        s_axis_tvalid = 0; s_axis_tlast = 0; m0_axis_tready = 0;
        chk("tlast_vs_to_no_pulse", timeout_pulse, 0);
        chk("tlast_vs_to_release", grant, 2'b00);
        tick();
        m_axis_tready = 1;

        // Asynchronous reset in the middle of a frame.
        m_axis_tready = 0;
        set_req(0, 1, 8'hA1);
        tick();
        chk("rst_mid_grant", grant, 2'b01);
        chk("rst_mid_valid", m_axis_tvalid, 1);
        #2;
        rst = 1;
        #1;
        chk("rst_async_grant", grant, 2'b00);
        chk("rst_async_valid", m_axis_tvalid, 0);
        @(posedge clk);
        #1;
        rst = 0;
        tick();
        chk("rst_regrant", grant, 2'b01);
        set_req(0, 0, 0);
        m0_axis_tready = 1; s_axis_tvalid = 1; s_axis_tdata = 8'h11; s_axis_tlast = 1;
        tick();
        s_axis_tvalid = 0; s_axis_tlast = 0; m0_axis_tready = 0;
        m_axis_tready = 1;

        // Two drops per cycle and saturation at 255.
        do_reset();
        set_req(0, 1, 8'h11);
        set_req(1, 1, 8'h22);
        tick();
        chk("drop_dual", drop_count, 2);
        for (int i = 0; i < 130; i++) tick();
        chk("drop_saturate", drop_count, 255);
        set_req(0, 0, 0);
        set_req(1, 0, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
